ctrl_unit_mc: RTL and testbench
===============================

CTRL_UNIT_MC -- requirements
Module: ctrl_unit_mc

Interface
REQ-001 SHALL: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL: reset  in  1  one clock; reset is synchronous and active-low (sampled only at clk rising edge; 0 = reset).
REQ-003 SHALL: opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; zero  in  1  ALU zero flag.
REQ-004 SHALL: PCWrite, IorD, MemWrite, IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite  out  1 each  datapath strobes.
REQ-005 SHALL: BancoWriteReg  out  3  write-register select: 0 rt, 1 rd, 2 rs, 3 $29 (SP), 4 $31 (link).
REQ-006 SHALL: MemToReg  out  2  write-data select: 0 ALUOut, 1 MDR, 2 PC, 3 constant 227.
REQ-007 SHALL: ALUSrcA  out  1 (0 PC, 1 A); ALUSrcB  out  2 (0 B, 1 const 4, 2 signext imm, 3 signext imm<<2).
REQ-008 SHALL: ALUOp  out  3 (000 none, 001 ADD, 010 SUB, 011 AND); PCSource  out  2 (0 ALU result, 1 ALUOut, 2 jump target, 3 A).
REQ-009 SHALL: state_out  out  5  current state code; illegal_op  out  1  unsupported-instruction flag.

Function
REQ-010 SHALL: Moore FSM; all outputs decoded from current state only, except PCWrite in BEQ (REQ-020); every output not listed for a state is 0.
REQ-011 SHALL: supported opcodes: 0x00 R-type (funct 0x20 add, 0x22 sub, 0x24 and, 0x08 jr), 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j, 0x03 jal.
REQ-012 SHALL: S_RST: RegWrite=1, BancoWriteReg=3, MemToReg=3 (SP <= 227); next FETCH0.
REQ-013 SHALL: FETCH0, FETCH1: memory wait, IorD=0, no strobes; FETCH1 -> FETCH2.
REQ-014 SHALL: FETCH2: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0; next DECODE.
REQ-015 SHALL: DECODE: ABWrite=1, ALUOutWrite=1, ALUSrcA=0, ALUSrcB=3, ALUOp=ADD; dispatch on opcode/funct.
REQ-016 SHALL: R_EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp per funct, ALUOutWrite=1 -> R_WB: RegWrite=1, BancoWriteReg=1, MemToReg=0 -> FETCH0.
REQ-017 SHALL: JR: PCWrite=1, PCSource=3 -> FETCH0.
REQ-018 SHALL: ADDI_EXEC and MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD, ALUOutWrite=1; ADDI_WB: RegWrite=1, BancoWriteReg=0, MemToReg=0 -> FETCH0.
REQ-019 SHALL: lw: MEM_RD0, MEM_RD1 (IorD=1), MEM_RD2 (IorD=1, MDRWrite=1), LW_WB (RegWrite=1, BancoWriteReg=0, MemToReg=1) -> FETCH0; sw: MEM_WR (IorD=1, MemWrite=1) -> FETCH0.
REQ-020 SHALL: BEQ: ALUSrcA=1, ALUSrcB=0, SUB, PCSource=1, PCWrite=zero -> FETCH0.
REQ-021 SHALL: J: PCWrite=1, PCSource=2 -> FETCH0; jal: JAL_LINK (RegWrite=1, BancoWriteReg=4, MemToReg=2) then J behaviour.
REQ-022 SHALL: unsupported opcode or R-type funct: ILLEGAL state, illegal_op=1 for exactly one cycle, no other strobes, -> FETCH0.
REQ-023 SHALL: instruction latency (first FETCH0 to next FETCH0): R 6, addi 6, lw 8, sw 6, beq 5, j 5, jal 6, jr 5, illegal 5 cycles.
REQ-024 SHALL: RegWrite and PCWrite never asserted in the same cycle; MemWrite only in MEM_WR.

Reset
REQ-025 SHALL: reset=0 at a clk edge forces state to S_RST from any state, including mid-instruction, discarding the instruction in progress.
REQ-026 SHALL: while reset held low, state stays S_RST (outputs per REQ-012); first cycle after release is S_RST, then FETCH0.

Verification
REQ-027 SHALL: reset low 3 cycles, release -> S_RST outputs (RegWrite=1, BancoWriteReg=3, MemToReg=3) one more cycle, then FETCH0.
REQ-028 SHALL: opcode 0x00 funct 0x20 -> R_WB with BancoWriteReg=1, RegWrite=1; back in FETCH0 6 cycles after start.
REQ-029 SHALL: opcode 0x23 -> MDRWrite=1 at MEM_RD2, LW_WB BancoWriteReg=0 MemToReg=1; 8-cycle latency.
REQ-030 SHALL: opcode 0x04 with zero=1 -> PCWrite=1 PCSource=1; zero=0 -> PCWrite=0.
REQ-031 SHALL: opcode 0x03 -> JAL_LINK BancoWriteReg=4 MemToReg=2, then PCWrite=1 PCSource=2; opcode 0x3F -> illegal_op pulse of 1 cycle.
REQ-032 SHALL: reset driven low during MEM_WR of sw -> next state S_RST, MemWrite=0 thereafter.

Source files
------------

// File: rtl/ctrl_unit_mc.sv
`default_nettype none
// ============================================================================
// ctrl_unit_mc : multicycle MIPS-subset control FSM with registered outputs
// Revision     : 1.0
// ============================================================================
module ctrl_unit_mc (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MDRWrite,
   output logic       ABWrite,
   output logic       ALUOutWrite,
   output logic       RegWrite,
   output logic [2:0] BancoWriteReg,
   output logic [1:0] MemToReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [4:0] state_out,
   output logic       illegal_op
);

   typedef enum logic [4:0] {
      S_RST     = 5'd0,  FETCH0   = 5'd1,  FETCH1  = 5'd2,  FETCH2  = 5'd3,
      DECODE    = 5'd4,  R_EXEC   = 5'd5,  R_WB    = 5'd6,  JR      = 5'd7,
      ADDI_EXEC = 5'd8,  ADDI_WB  = 5'd9,  MEM_ADDR = 5'd10, MEM_RD0 = 5'd11,
      MEM_RD1   = 5'd12, MEM_RD2  = 5'd13, LW_WB   = 5'd14, MEM_WR  = 5'd15,
      BEQ       = 5'd16, J        = 5'd17, JAL_LINK = 5'd18, ILLEGAL = 5'd19
   } state_t;

   state_t state;
   state_t nxt;
   logic   pc_write_st;

   always_comb begin
      nxt = FETCH0;
      case (state)
         S_RST:     nxt = FETCH0;
         FETCH0:    nxt = FETCH1;
         FETCH1:    nxt = FETCH2;
         FETCH2:    nxt = DECODE;
         DECODE: begin
            case (opcode)
               6'h00: begin
                  case (funct)
                     6'h20, 6'h22, 6'h24: nxt = R_EXEC;
                     6'h08:               nxt = JR;
                     default:             nxt = ILLEGAL;
                  endcase
               end
               6'h08:   nxt = ADDI_EXEC;
               6'h23:   nxt = MEM_RD0;
               6'h2B:   nxt = MEM_ADDR;
               6'h04:   nxt = BEQ;
               6'h02:   nxt = J;
               6'h03:   nxt = JAL_LINK;
               default: nxt = ILLEGAL;
            endcase
         end
         R_EXEC:    nxt = R_WB;
         ADDI_EXEC: nxt = ADDI_WB;
         MEM_ADDR:  nxt = MEM_WR;
         MEM_RD0:   nxt = MEM_RD1;
         MEM_RD1:   nxt = MEM_RD2;
         MEM_RD2:   nxt = LW_WB;
         JAL_LINK:  nxt = J;
         default:   nxt = FETCH0;
      endcase
   end

   // Outputs are decoded from the state being entered so they line up with it.
   always_ff @(posedge clk) begin
      pc_write_st   <= 1'b0;
      IorD          <= 1'b0;
      MemWrite      <= 1'b0;
      IRWrite       <= 1'b0;
      MDRWrite      <= 1'b0;
      ABWrite       <= 1'b0;
      ALUOutWrite   <= 1'b0;
      RegWrite      <= 1'b0;
      BancoWriteReg <= 3'd0;
      MemToReg      <= 2'd0;
      ALUSrcA       <= 1'b0;
      ALUSrcB       <= 2'd0;
      ALUOp         <= 3'b000;
      PCSource      <= 2'd0;
      illegal_op    <= 1'b0;
      if (!reset) begin
         state         <= S_RST;
         RegWrite      <= 1'b1;
         BancoWriteReg <= 3'd3;
         MemToReg      <= 2'd3;
      end else begin
         state <= nxt;
         case (nxt)
            S_RST: begin
               RegWrite      <= 1'b1;
               BancoWriteReg <= 3'd3;
               MemToReg      <= 2'd3;
            end
            FETCH2: begin
               IRWrite     <= 1'b1;
               pc_write_st <= 1'b1;
               ALUSrcB     <= 2'd1;
               ALUOp       <= 3'b001;
            end
            DECODE: begin
               ABWrite     <= 1'b1;
               ALUOutWrite <= 1'b1;
               ALUSrcB     <= 2'd3;
               ALUOp       <= 3'b001;
            end
            R_EXEC: begin
               ALUSrcA     <= 1'b1;
               ALUOutWrite <= 1'b1;
               case (funct)
                  6'h22:   ALUOp <= 3'b010;
                  6'h24:   ALUOp <= 3'b011;
                  default: ALUOp <= 3'b001;
               endcase
            end
            R_WB: begin
               RegWrite      <= 1'b1;
               BancoWriteReg <= 3'd1;
            end
            JR: begin
               pc_write_st <= 1'b1;
               PCSource    <= 2'd3;
            end
            // MEM_RD0 is the lw address cycle, keeping lw at two memory-wait cycles.
            ADDI_EXEC, MEM_ADDR, MEM_RD0: begin
               ALUSrcA     <= 1'b1;
               ALUSrcB     <= 2'd2;
               ALUOp       <= 3'b001;
               ALUOutWrite <= 1'b1;
            end
            ADDI_WB:  RegWrite <= 1'b1;
            MEM_RD1:  IorD <= 1'b1;
            MEM_RD2: begin
               IorD     <= 1'b1;
               MDRWrite <= 1'b1;
            end
            LW_WB: begin
               RegWrite <= 1'b1;
               MemToReg <= 2'd1;
            end
            MEM_WR: begin
               IorD     <= 1'b1;
               MemWrite <= 1'b1;
            end
            BEQ: begin
               ALUSrcA  <= 1'b1;
               ALUOp    <= 3'b010;
               PCSource <= 2'd1;
            end
            J: begin
               pc_write_st <= 1'b1;
               PCSource    <= 2'd2;
            end
            JAL_LINK: begin
               RegWrite      <= 1'b1;
               BancoWriteReg <= 3'd4;
               MemToReg      <= 2'd2;
            end
            ILLEGAL:  illegal_op <= 1'b1;
            default: ;
         endcase
      end
   end

   // Branch decision needs the live zero flag, so it bypasses the output register.
   assign PCWrite   = pc_write_st | ((state == BEQ) & zero);
   assign state_out = state;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit_mc.sv
`default_nettype none
// ============================================================================
// tb_ctrl_unit_mc : randomized scoreboard bench for ctrl_unit_mc
// Revision        : 1.0
// ============================================================================
module tb_ctrl_unit_mc;

   typedef struct packed {
      logic       pcw, iord, memw, irw, mdrw, abw, aluoutw, regw;
      logic [2:0] bwr;
      logic [1:0] m2r;
      logic       srca;
      logic [1:0] srcb;
      logic [2:0] aluop;
      logic [1:0] pcsrc;
      logic       ill;
   } out_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       PCWrite, IorD, MemWrite, IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite;
   logic [2:0] BancoWriteReg;
   logic [1:0] MemToReg;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUOp;
   logic [1:0] PCSource;
   logic [4:0] state_out;
   logic       illegal_op;

   int   errors = 0;
   int   checks = 0;
   out_t exp_q[$];
   out_t cur[$];

   ctrl_unit_mc dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MDRWrite(MDRWrite), .ABWrite(ABWrite), .ALUOutWrite(ALUOutWrite),
      .RegWrite(RegWrite), .BancoWriteReg(BancoWriteReg), .MemToReg(MemToReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .state_out(state_out), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   function automatic out_t rst_rec();
      out_t o = '0;
      o.regw = 1'b1; o.bwr = 3'd3; o.m2r = 2'd3;
      return o;
   endfunction

   // Reference: per-cycle strobe list for one instruction, FETCH0 first.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
      out_t o;
      cur.delete();
      o = '0; cur.push_back(o); cur.push_back(o);
      o = '0; o.irw = 1; o.pcw = 1; o.srcb = 2'd1; o.aluop = 3'd1; cur.push_back(o);
      o = '0; o.abw = 1; o.aluoutw = 1; o.srcb = 2'd3; o.aluop = 3'd1; cur.push_back(o);
      if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
         o = '0; o.srca = 1; o.aluoutw = 1;
         o.aluop = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3;
         cur.push_back(o);
         o = '0; o.regw = 1; o.bwr = 3'd1; cur.push_back(o);
      end else if (op == 6'h00 && fn == 6'h08) begin
         o = '0; o.pcw = 1; o.pcsrc = 2'd3; cur.push_back(o);
      end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
         o = '0; o.srca = 1; o.srcb = 2'd2; o.aluop = 3'd1; o.aluoutw = 1; cur.push_back(o);
         if (op == 6'h08) begin
            o = '0; o.regw = 1; cur.push_back(o);
         end else if (op == 6'h2B) begin
            o = '0; o.iord = 1; o.memw = 1; cur.push_back(o);
         end else begin
            o = '0; o.iord = 1; cur.push_back(o);
            o.mdrw = 1; cur.push_back(o);
            o = '0; o.regw = 1; o.m2r = 2'd1; cur.push_back(o);
         end
      end else if (op == 6'h04) begin
         o = '0; o.srca = 1; o.aluop = 3'd2; o.pcsrc = 2'd1; o.pcw = z; cur.push_back(o);
      end else if (op == 6'h02 || op == 6'h03) begin
         if (op == 6'h03) begin
            o = '0; o.regw = 1; o.bwr = 3'd4; o.m2r = 2'd2; cur.push_back(o);
         end
         o = '0; o.pcw = 1; o.pcsrc = 2'd2; cur.push_back(o);
      end else begin
         o = '0; o.ill = 1; cur.push_back(o);
      end
   endtask

   // Entered at #1 after the edge into FETCH0; abort_at>0 pulls reset low in that cycle.
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int abort_at, input int hold);
      int n;
      build(op, fn, z);
      n = (abort_at > 0) ? abort_at + 1 : cur.size();
      for (int i = 0; i < n; i++) exp_q.push_back(cur[i]);
      if (abort_at > 0)
         for (int i = 0; i < hold; i++) exp_q.push_back(rst_rec());
      opcode = op; funct = fn; zero = z;
      if (abort_at > 0) begin
         repeat (abort_at) @(posedge clk);
         #1 reset = 1'b0;
         repeat (hold) @(posedge clk);
         #1 reset = 1'b1;
         @(posedge clk);
         #1;
      end else begin
         repeat (cur.size()) @(posedge clk);
         #1;
      end
   endtask

   // Monitor: one expected record per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      out_t e, g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = '{PCWrite, IorD, MemWrite, IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite,
               BancoWriteReg, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL outputs t=%0t state=%0d got=%h expected=%h", $time, state_out, g, e);
         end
         checks++;
         if (RegWrite === 1'b1 && PCWrite === 1'b1) begin
            errors++;
            $display("FAIL regw_pcw_excl t=%0t got=11 expected=not both", $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] ops [10];
      logic [5:0] fns [5];
      logic [5:0] op, fn;
      int         len;
      ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F};
      fns = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h3F};

      // Reset low for three edges; the cycle after release is still S_RST.
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) exp_q.push_back(rst_rec());
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      run(6'h00, 6'h20, 1'b0, 0, 0);
      run(6'h23, 6'h00, 1'b0, 0, 0);
      run(6'h04, 6'h00, 1'b1, 0, 0);
      run(6'h04, 6'h00, 1'b0, 0, 0);
      run(6'h03, 6'h00, 1'b0, 0, 0);
      run(6'h3F, 6'h00, 1'b0, 0, 0);
      run(6'h00, 6'h08, 1'b1, 0, 0);
      run(6'h2B, 6'h00, 1'b0, 5, 1);
      run(6'h2B, 6'h00, 1'b0, 0, 0);

      for (int k = 0; k < 250; k++) begin
         op = ops[$urandom_range(9)];
         fn = fns[$urandom_range(4)];
         if ($urandom_range(9) == 0) op = 6'($urandom);
         if ($urandom_range(9) == 0) fn = 6'($urandom);
         build(op, fn, 1'b0);
         len = cur.size();
         if ($urandom_range(9) == 0)
            run(op, fn, 1'($urandom), $urandom_range(len - 1, 1), $urandom_range(3, 1));
         else
            run(op, fn, 1'($urandom), 0, 0);
      end

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d expected=0 pending records", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
